frog_move_ctrl: RTL and testbench

//  Input conditioner upstream of the frog game core. Synchronises and debounces SW1-SW4 and

---
 rtl/frog_move_ctrl_pkg.sv | 33 +++
 rtl/frog_move_ctrl_if.sv | 14 +
 rtl/frog_move_ctrl_debounce.sv | 47 ++++
 rtl/frog_move_ctrl.sv | 118 +++++++++++
 tb/tb_frog_move_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/frog_move_ctrl_pkg.sv
// Shared definitions for the frog move controller: direction and FSM state
// encodings, default cycle counts and the press-arbitration helper.
package frog_move_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    COOLDOWN = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_COOLDOWN_CYCLES = 2500000;
  localparam int DEF_REPEAT_CYCLES   = 5000000;
  localparam int DEF_CNT_W           = 32;

  // Fixed priority UP > DOWN > LEFT > RIGHT; bit i of presses is switch i+1.
  // Only meaningful when at least one bit is set.
  function automatic logic [1:0] pick_dir(input logic [3:0] presses);
    if (presses[0])      pick_dir = DIR_UP;
    else if (presses[1]) pick_dir = DIR_DOWN;
    else if (presses[2]) pick_dir = DIR_LEFT;
    else                 pick_dir = DIR_RIGHT;
  endfunction

endpackage

// File: rtl/frog_move_ctrl_if.sv
// Move-request channel between the input conditioner and the movement logic.
//
// Handshake: a move transfers on a clock edge where move_valid and move_ready
// are both 1. Once move_valid is raised, it and move_dir stay stable until
// that transfer (only reset may withdraw a pending request). move_ready may be
// tied high and may depend on nothing from this channel.
interface frog_move_ctrl_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/frog_move_ctrl_debounce.sv
// frog_debounce: one switch worth of 2-flop synchroniser, debounce counter and
// press strobe. The debounced level follows the synchronised level only after
// it has differed for DEBOUNCE_CYCLES consecutive cycles.
module frog_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then count how long the synced level disagrees with the debounced one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/frog_move_ctrl.sv
// frog_move_ctrl: conditions SW1..SW4 into one move request per press, with a
// post-move cooldown. Define FROG_AUTO_REPEAT_EN to re-issue the held
// direction every REPEAT_CYCLES while the switch stays pressed in HOLD.
module frog_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COOLDOWN_CYCLES = 2500000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW1,
  input  logic              SW2,
  input  logic              SW3,
  input  logic              SW4,
  frog_move_ctrl_if.master  mv,
  output logic [3:0]        btn_level,
  output logic [1:0]        dbg_state
);
  import frog_move_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
`ifdef FROG_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [3:0]       sw;
  logic [3:0]       press;
  logic [3:0]       hold_press;
  state_t           state;
  state_t           state_nx;
  logic [1:0]       dir_q;
  logic [1:0]       dir_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  assign sw = {SW4, SW3, SW2, SW1};

  for (genvar g = 0; g < 4; g++) begin : g_db
    frog_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk   (CLK),
      .rst   (RST),
      .raw   (sw[g]),
      .level (btn_level[g]),
      .press (press[g])
    );
  end

  // In HOLD only presses on switches other than the latched one start a new move.
  assign hold_press = press & ~(4'd1 << dir_q);

  // State, latched direction and the shared cooldown/repeat counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      dir_q <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      dir_q <= dir_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; counters stop at their terminal value so they never wrap.
  always_comb begin
    state_nx = state;
    dir_nx   = dir_q;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (|press) begin
          dir_nx   = pick_dir(press);
          state_nx = VALID;
        end
      end
      VALID: begin
        if (mv.move_ready) begin
          state_nx = COOLDOWN;
          cnt_nx   = '0;
        end
      end
      COOLDOWN: begin
        if (cnt == COOL_LAST) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (|hold_press) begin
          dir_nx   = pick_dir(hold_press);
          state_nx = VALID;
        end else if (!btn_level[dir_q]) begin
          state_nx = IDLE;
        end
`ifdef FROG_AUTO_REPEAT_EN
        else if (cnt == RPT_LAST) begin
          state_nx = VALID;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mv.move_valid = (state == VALID);
  assign mv.move_dir   = dir_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Directed bench for frog_move_ctrl with short debounce/cooldown/repeat counts.
module tb_frog_move_ctrl;

  localparam int DEB  = 4;
  localparam int COOL = 8;
  localparam int RPT  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic       sw3 = 1'b0;
  logic       sw4 = 1'b0;
  logic [3:0] btn_level;
  logic [1:0] dbg_state;

  frog_move_ctrl_if mv_if ();

  frog_move_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .COOLDOWN_CYCLES (COOL),
    .REPEAT_CYCLES   (RPT),
    .CNT_W           (32)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .SW1       (sw1),
    .SW2       (sw2),
    .SW3       (sw3),
    .SW4       (sw4),
    .mv        (mv_if),
    .btn_level (btn_level),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int         n_checks = 0;
  int         n_pass   = 0;
  int         xfer_cnt = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    if (!rst && mv_if.move_valid && mv_if.move_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) check("xfer_pending", 32'(exp_q.size()), 32'd1);
      else check("xfer_dir", 32'(mv_if.move_dir), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks
  task automatic settle(input string tag);
    sw1 = 1'b0; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
    mv_if.move_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd0 && btn_level == 4'd0) break;
    end
    check({tag, "_idle"}, 32'(dbg_state), 32'd0);
    check({tag, "_btn0"}, 32'(btn_level), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (mv_if.move_valid) break;
      @(negedge clk);
    end
    check(tag, 32'(mv_if.move_valid), 32'd1);
  endtask

  // Stimulus
  int   x0;
  logic flag;

  initial begin
    mv_if.move_ready = 1'b1;
    sw1 = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(mv_if.move_valid), 32'd0);
    check("reset_btn",   32'(btn_level), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_dir",   32'(mv_if.move_dir), 32'd0);

    // 1: SW1 held through reset; request appears 2+DEB+1 edges after release
    exp_q.push_back(2'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_btn_e6",   32'(btn_level), 32'd1);
    check("t1_valid_e6", 32'(mv_if.move_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_e7", 32'(mv_if.move_valid), 32'd1);
    check("t1_dir_e7",   32'(mv_if.move_dir), 32'd0);
    @(negedge clk);
    check("t1_valid_drop", 32'(mv_if.move_valid), 32'd0);
    check("t1_cooldown",   32'(dbg_state), 32'd2);
    settle("t1");

    // 2: 3-cycle glitch on SW3 is filtered out
    x0 = xfer_cnt;
    sw3 = 1'b1;
    repeat (3) @(negedge clk);
    sw3 = 1'b0;
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (btn_level[2] || mv_if.move_valid) flag = 1'b1;
    end
    check("t2_glitch", 32'(flag), 32'd0);
    check("t2_xfers",  32'(xfer_cnt - x0), 32'd0);

    // 3: SW2 and SW4 together -> only DOWN
    x0 = xfer_cnt;
    exp_q.push_back(2'd1);
    sw2 = 1'b1; sw4 = 1'b1;
    repeat (30) @(negedge clk);
    check("t3_xfers", 32'(xfer_cnt - x0), 32'd1);
    check("t3_btn",   32'(btn_level), 32'd10);
    check("t3_hold",  32'(dbg_state), 32'd3);
    settle("t3");

    // 3b: SW1 and SW3 together -> only UP
    x0 = xfer_cnt;
    exp_q.push_back(2'd0);
    sw1 = 1'b1; sw3 = 1'b1;
    repeat (30) @(negedge clk);
    check("t3b_xfers", 32'(xfer_cnt - x0), 32'd1);
    settle("t3b");

    // 4: backpressure holds valid and dir
    x0 = xfer_cnt;
    mv_if.move_ready = 1'b0;
    exp_q.push_back(2'd2);
    sw3 = 1'b1;
    wait_valid("t4_valid", 20);
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(mv_if.move_valid && mv_if.move_dir == 2'd2)) flag = 1'b0;
      @(negedge clk);
    end
    check("t4_held",    32'(flag), 32'd1);
    check("t4_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    mv_if.move_ready = 1'b1;
    @(negedge clk);
    check("t4_xfer",      32'(xfer_cnt - x0), 32'd1);
    check("t4_valid_low", 32'(mv_if.move_valid), 32'd0);
    settle("t4");

    // 5: press during COOLDOWN is dropped, press in HOLD is taken
    x0 = xfer_cnt;
    exp_q.push_back(2'd0);
    sw1 = 1'b1;
    wait_valid("t5_valid", 20);
    @(negedge clk);
    check("t5_cool", 32'(dbg_state), 32'd2);
    sw4 = 1'b1;
    repeat (8) @(negedge clk);
    sw4 = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_hold", 32'(dbg_state), 32'd3);
    check("t5_btn",  32'(btn_level), 32'd1);
    check("t5_drop", 32'(xfer_cnt - x0), 32'd1);
    exp_q.push_back(2'd3);
    sw4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (xfer_cnt - x0 == 2) break;
      @(negedge clk);
    end
    check("t5_second", 32'(xfer_cnt - x0), 32'd2);
    settle("t5");

    // 6: long hold of SW2
    x0 = xfer_cnt;
    exp_q.push_back(2'd1);
`ifdef FROG_AUTO_REPEAT_EN
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
`endif
    sw2 = 1'b1;
    wait_valid("t6_valid", 20);
    repeat (60) @(negedge clk);
`ifdef FROG_AUTO_REPEAT_EN
    check("t6_xfers", 32'(xfer_cnt - x0), 32'd3);
`else
    check("t6_xfers", 32'(xfer_cnt - x0), 32'd1);
`endif
    settle("t6");

    // 7: reset while a request is pending drops it at once
    x0 = xfer_cnt;
    mv_if.move_ready = 1'b0;
    sw3 = 1'b1;
    wait_valid("t7_valid", 20);
    rst = 1'b1;
    #1;
    check("t7_async_valid", 32'(mv_if.move_valid), 32'd0);
    check("t7_async_dir",   32'(mv_if.move_dir), 32'd0);
    check("t7_async_btn",   32'(btn_level), 32'd0);
    @(negedge clk);
    sw3 = 1'b0;
    mv_if.move_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    settle("t7");
    check("t7_lost", 32'(xfer_cnt - x0), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
